fex7_seq: RTL and testbench

Sequencer for the 8-element factorial-expansion permutation network `fex7perm`. Holds the seven factorial-base digits f1..f7 (rank 0..40319) in a mixed-radix counter and steps it up or down on request or on an internal period tick. Loads digits directly and validates them. Registers the resulting permutation and presents it over a valid/ready handshake, for the voice/note-ordering logic downstream.

---
 rtl/fex_pkg.sv | 51 +++++
 rtl/fex7perm.sv | 33 +++
 rtl/fex7_seq.sv | 169 ++++++++++++++++
 tb/tb_fex7_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fex_pkg.sv
// Shared types and constants for the fex7 factorial-expansion sequencer.
// Digit fk (k = 1..7) lives in radix k+1; f1 is least significant.
package fex_pkg;

  localparam int NDIG = 7;
  localparam int DW = 17;
  localparam int PERMW = 24;

  // Slot 0 is an unused zero-width slot so loops can run 0..7 uniformly.
  localparam int F_LSB [8] = '{0, 0, 1, 3, 5, 8, 11, 14};
  localparam int F_W [8] = '{0, 1, 2, 2, 3, 3, 3, 3};

  typedef logic [7:0][2:0] digv_t;

  localparam digv_t DIG_MAX = {
    3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
  };

  localparam logic [PERMW-1:0] FEX7_IDENTITY = 24'hFAC688;
  localparam logic [DW-1:0] FEX7_MAXDIGITS = 17'h1F59D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPTURE = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  typedef struct packed {
    logic wrap;
    digv_t v;
  } rstep_t;

  function automatic digv_t unpack_digits(logic [DW-1:0] d);
    digv_t v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k] = 3'((d >> F_LSB[k]) & ((17'd1 << F_W[k]) - 17'd1));
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] pack_digits(digv_t v);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      d = d | (17'(v[k]) << F_LSB[k]);
    end
    return d;
  endfunction

endpackage

// File: rtl/fex7perm.sv
// Factorial-expansion permutation network: for k = 1..7 swap
// element k with element k - fk, starting from the identity.
module fex7perm
  import fex_pkg::*;
(
  input  logic [16:0] digits,
  output logic [23:0] perm
);

  digv_t v;
  logic [7:0][2:0] a;
  logic [2:0] j;
  logic [2:0] t;

  always_comb begin
    v = unpack_digits(digits);
    j = '0;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      a[i] = 3'(i);
    end
    // Slot 0 has digit 0, so its swap is a no-op.
    for (int k = 0; k < 8; k++) begin
      j = 3'(k) - v[k];
      t = a[k];
      a[k] = a[j];
      a[j] = t;
    end
  end

  assign perm = a;

endmodule

// File: rtl/fex7_seq.sv
// Mixed-radix rank sequencer driving fex7perm, with load/validate,
// auto-run period tick and a registered valid/ready output stage.
module fex7_seq
  import fex_pkg::*;
#(
  parameter int PERIOD = 16,
  parameter int PW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        dir,
  input  logic        auto_run,
  input  logic        load,
  input  logic [16:0] load_digits,
  output logic        load_err,
  output logic [16:0] digits,
  output logic [23:0] perm,
  output logic        perm_wrap,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [PW-1:0] CNT_LAST = PW'(PERIOD - 1);

  function automatic rstep_t radix_step(logic [16:0] d, logic up);
    rstep_t r;
    logic c;
    r.v = unpack_digits(d);
    c = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (c) begin
        if (up) begin
          if (r.v[k] == DIG_MAX[k]) begin
            r.v[k] = '0;
          end else begin
            r.v[k] = r.v[k] + 3'd1;
            c = 1'b0;
          end
        end else begin
          if (r.v[k] == 3'd0) begin
            r.v[k] = DIG_MAX[k];
          end else begin
            r.v[k] = r.v[k] - 3'd1;
            c = 1'b0;
          end
        end
      end
    end
    r.wrap = c;
    return r;
  endfunction

  function automatic logic digits_ok(logic [16:0] d);
    digv_t v;
    logic ok;
    v = unpack_digits(d);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (v[k] > DIG_MAX[k]) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t state_q, state_d;
  logic [16:0] digits_q, digits_d;
  logic wrap_q, wrap_d;
  logic [23:0] perm_q, perm_d;
  logic perm_wrap_q, perm_wrap_d;
  logic out_valid_q, out_valid_d;
  logic load_err_q, load_err_d;
  logic [PW-1:0] cnt_q, cnt_d;

  logic [23:0] perm_w;
  rstep_t nxt;
  logic ld_ok;
  logic tick;

  fex7perm u_perm (
    .digits(digits_q),
    .perm  (perm_w)
  );

  assign nxt = radix_step(digits_q, dir);
  assign ld_ok = digits_ok(load_digits);
  assign tick = auto_run & (cnt_q == CNT_LAST)
              & (state_q == S_IDLE);

  always_comb begin
    cnt_d = '0;
    if (auto_run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    wrap_d = wrap_q;
    perm_d = perm_q;
    perm_wrap_d = perm_wrap_q;
    out_valid_d = out_valid_q;
    load_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          if (ld_ok) begin
            digits_d = load_digits;
            wrap_d = 1'b0;
            state_d = S_CAPTURE;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (step | tick) begin
          digits_d = pack_digits(nxt.v);
          wrap_d = nxt.wrap;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        perm_d = perm_w;
        perm_wrap_d = wrap_q;
        out_valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      digits_q <= '0;
      wrap_q <= 1'b0;
      perm_q <= FEX7_IDENTITY;
      perm_wrap_q <= 1'b0;
      out_valid_q <= 1'b0;
      load_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      wrap_q <= wrap_d;
      perm_q <= perm_d;
      perm_wrap_q <= perm_wrap_d;
      out_valid_q <= out_valid_d;
      load_err_q <= load_err_d;
      cnt_q <= cnt_d;
    end
  end

  assign load_err = load_err_q;
  assign digits = digits_q;
  assign perm = perm_q;
  assign perm_wrap = perm_wrap_q;
  assign out_valid = out_valid_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fex7_seq.sv
// Scoreboard bench for fex7_seq: a rank-integer model predicts each
// delivered permutation; a monitor pops and compares on handshakes.
module tb_fex7_seq;

  logic clk = 1'b0;
  logic rst, step, dir, auto_run, load, out_ready;
  logic [16:0] load_digits;
  logic load_err, perm_wrap, out_valid, busy;
  logic [16:0] digits;
  logic [23:0] perm;

  always #5 clk = ~clk;

  fex7_seq #(.PERIOD(4), .PW(16)) dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir),
    .auto_run(auto_run), .load(load),
    .load_digits(load_digits), .load_err(load_err),
    .digits(digits), .perm(perm), .perm_wrap(perm_wrap),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic [23:0] perm;
    logic wrap;
    logic [16:0] dig;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int passed = 0;
  int hs_cnt = 0;
  time hs_t = 0;
  bit rand_rdy = 0;
  int rank = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  function automatic int fld(logic [16:0] d, int k);
    case (k)
      1: return int'(d[0]);
      2: return int'(d[2:1]);
      3: return int'(d[4:3]);
      4: return int'(d[7:5]);
      5: return int'(d[10:8]);
      6: return int'(d[13:11]);
      default: return int'(d[16:14]);
    endcase
  endfunction

  function automatic bit valid_d(logic [16:0] d);
    for (int k = 1; k <= 7; k++) if (fld(d, k) > k) return 0;
    return 1;
  endfunction

  function automatic int rank_of(logic [16:0] d);
    int r = fld(d, 7);
    for (int k = 6; k >= 1; k--) r = r * (k + 1) + fld(d, k);
    return r;
  endfunction

  function automatic logic [16:0] digits_of(int r);
    int f[8];
    for (int k = 1; k <= 7; k++) begin
      f[k] = r % (k + 1);
      r = r / (k + 1);
    end
    return {3'(f[7]), 3'(f[6]), 3'(f[5]), 3'(f[4]),
            2'(f[3]), 2'(f[2]), 1'(f[1])};
  endfunction

  function automatic logic [23:0] perm_of(int r);
    int a[8];
    int j, t;
    logic [16:0] d = digits_of(r);
    logic [23:0] p = '0;
    for (int i = 0; i < 8; i++) a[i] = i;
    for (int k = 1; k <= 7; k++) begin
      j = k - fld(d, k);
      t = a[k]; a[k] = a[j]; a[j] = t;
    end
    for (int i = 0; i < 8; i++) p[3*i +: 3] = 3'(a[i]);
    return p;
  endfunction

  function automatic bit adv(bit up);
    if (up) begin
      if (rank == 40319) begin rank = 0; return 1; end
      rank++;
    end else begin
      if (rank == 0) begin rank = 40319; return 1; end
      rank--;
    end
    return 0;
  endfunction

  function automatic void push_rank(bit w);
    q.push_back('{perm_of(rank), w, digits_of(rank)});
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output perm=%0h", perm);
      end else begin
        e = q.pop_front();
        chk("sb_perm", perm, e.perm);
        chk("sb_wrap", perm_wrap, e.wrap);
        chk("sb_digits", digits, e.dig);
      end
      hs_cnt++;
      hs_t = $time;
    end
  end

  task automatic wait_hs(input int tgt, input string nm);
    int n = 0;
    while (hs_cnt < tgt && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rand_rdy && hs_cnt < tgt)
        out_ready = 1'($urandom_range(0, 1));
    end
    chk(nm, 32'(hs_cnt >= tgt), 1);
  endtask

  task automatic req(input bit ld, input logic [16:0] ldv,
                     input bit st, input bit d);
    int tgt = hs_cnt + 1;
    logic [16:0] old = digits_of(rank);
    bit w = 0;
    load = ld; load_digits = ldv; step = st; dir = d;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    load = 0; step = 0;
    if (ld && !valid_d(ldv)) begin
      chk("load_err", load_err, 1);
      chk("err_digits", digits, old);
      chk("err_busy", busy, 0);
      @(posedge clk); #1;
      chk("load_err_clr", load_err, 0);
      return;
    end
    if (ld) rank = rank_of(ldv);
    else w = adv(d);
    push_rank(w);
    chk("e0_digits", digits, digits_of(rank));
    chk("e0_busy", busy, 1);
    wait_hs(tgt, "hs_req");
  endtask

  initial begin
    int tgt;
    int n;
    time prev;
    logic [16:0] lv;
    rst = 1; step = 0; dir = 0; auto_run = 0; load = 0;
    load_digits = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_perm", perm, 24'hFAC688);
    chk("rst_digits", digits, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_wrap", perm_wrap, 0);
    rst = 0;
    @(posedge clk); #1;

    step = 1; dir = 1;
    @(posedge clk); #1;
    step = 0;
    void'(adv(1));
    push_rank(0);
    chk("t2_digits", digits, 17'h00001);
    chk("t2_valid_e0", out_valid, 0);
    @(posedge clk); #1;
    chk("t2_perm", perm, 24'hFAC681);
    chk("t2_valid", out_valid, 1);
    wait_hs(1, "t2_hs");
    chk("t2_valid_drop", out_valid, 0);

    req(1, 17'h1F59D, 0, 0);
    req(0, 17'h0, 1, 1);
    chk("t3_zero", digits, 0);
    chk("t3_id", perm, 24'hFAC688);
    req(0, 17'h0, 1, 0);
    chk("t3_max", digits, 17'h1F59D);

    req(1, 17'h00006, 0, 0);
    chk("t4_no_valid", out_valid, 0);
    lv = digits_of(12345);
    req(1, lv, 1, 1);
    chk("t4_load_wins", digits, lv);

    out_ready = 0; step = 1; dir = 1;
    tgt = hs_cnt + 1;
    @(posedge clk); #1;
    void'(adv(1));
    push_rank(0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_perm", perm, perm_of(rank));
      chk("t5_digits", digits, digits_of(rank));
      chk("t5_busy", busy, 1);
      chk("t5_valid", out_valid, 1);
      step = 1'(i & 1);
      @(posedge clk); #1;
    end
    step = 0; out_ready = 1;
    wait_hs(tgt, "t5_hs");
    chk("t5_idle", busy, 0);
    chk("t5_once", hs_cnt, tgt);
    chk("t5_q_empty", q.size(), 0);

    rand_rdy = 1;
    repeat (40) begin
      case ($urandom_range(0, 4))
        0: req(1, digits_of($urandom_range(0, 40319)), 0, 0);
        1: req(1, 17'($urandom), 0, 0);
        2: req(0, 17'h0, 1, 1);
        3: req(0, 17'h0, 1, 0);
        default: req(1, digits_of($urandom_range(0, 40319)),
                     1, 1'($urandom_range(0, 1)));
      endcase
    end
    rand_rdy = 0; out_ready = 1;

    for (int i = 0; i < 4; i++) push_rank(adv(1));
    auto_run = 1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_hs(hs_cnt + 1, "t6_hs");
      if (i > 0) chk("t6_period", 32'(hs_t - prev), 40);
      prev = hs_t;
    end
    out_ready = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_present", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_perm", perm, 24'hFAC688);
    chk("t6_rst_digits", digits, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wrap", perm_wrap, 0);
    rank = 0;
    auto_run = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("t6_q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
